// File: rtl/status_cond_ctrl.sv
// rtl/status_cond_ctrl.sv - NZCV status register, condition evaluation and flag-hazard stall
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_cond           ARM condition field of the ID instruction
//   id_s              ID instruction requests a flag update
//   freeze            global pipeline hold
//   flush             branch taken in EXE; kills the ID instruction
//   exe_status        ALU status of the EXE instruction, {Z,C,N,V}
//   id_exec           ID instruction passes its condition and may commit
//   flag_stall        hold IF/ID this cycle and bubble EXE
//   alu_carry_in      SR.C to the ALU
//   sr_q              current SR, {Z,C,N,V}
//   exe_s_q           EXE holds a valid flag-setting instruction
module status_cond_ctrl #(
  parameter int COND_W = 4,
  parameter int SR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [COND_W-1:0] id_cond,
  input  logic              id_s,
  input  logic              freeze,
  input  logic              flush,
  input  logic [SR_W-1:0]   exe_status,
  output logic              id_exec,
  output logic              flag_stall,
  output logic              alu_carry_in,
  output logic [SR_W-1:0]   sr_q,
  output logic              exe_s_q
);

  logic flag_z, flag_c, flag_n, flag_v;
  logic cond_pass;
  logic exe_valid_q;

  assign flag_z = sr_q[3];
  assign flag_c = sr_q[2];
  assign flag_n = sr_q[1];
  assign flag_v = sr_q[0];

  // Unknown conditions fall to the default arm, so an undriven id_cond
  // never leaks X; id_valid gating below forces the outputs low anyway.
  always_comb begin
    cond_pass = 1'b0;
    case (id_cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Flags are never forwarded from exe_status: any conditional ID
  // instruction behind a flag setter waits one cycle instead.
  assign flag_stall   = id_valid & exe_s_q & (id_cond != 4'b1110) & ~flush;
  assign id_exec      = id_valid & cond_pass & ~flag_stall & ~flush;
  assign alu_carry_in = sr_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q        <= '0;
      exe_valid_q <= 1'b0;
      exe_s_q     <= 1'b0;
    end else if (!freeze) begin
      // The EXE instruction commits its flags even when it is the branch
      // that is flushing ID.
      if (exe_valid_q && exe_s_q) begin
        sr_q <= exe_status;
      end
      if (flush || flag_stall) begin
        exe_valid_q <= 1'b0;
        exe_s_q     <= 1'b0;
      end else begin
        exe_valid_q <= id_exec;
        exe_s_q     <= id_exec & id_s;
      end
    end
  end

endmodule

// File: doc/status_cond_ctrl.md
Name: status_cond_ctrl

Overview:
- Owns the architectural NZCV status register (SR) for the in-order ARM pipeline.
- Evaluates the 4-bit condition field of the instruction in ID against SR and decides whether that instruction executes.
- Tracks whether the instruction in EXE will set flags, and stalls ID for one cycle on a flag hazard.
- Writes the ALU status into SR when a flag-setting instruction leaves EXE, and drives the ALU carry input from SR.C.

Parameters:
- COND_W, 4, condition field width (fixed; do not override)
- SR_W, 4, status width; bit order {Z,C,N,V}, MSB first, matching the ALU status output

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_cond  in  4  ARM condition field of the ID instruction
- id_s  in  1  ID instruction requests a flag update (S bit)
- freeze  in  1  global pipeline hold (memory wait)
- flush  in  1  branch taken in EXE; kill the ID instruction
- exe_status  in  4  ALU status of the current EXE instruction, {Z,C,N,V}
- id_exec  out  1  ID instruction passes its condition and may commit
- flag_stall  out  1  hold IF/ID this cycle, insert bubble into EXE
- alu_carry_in  out  1  SR.C, wired to the ALU carry input
- sr_q  out  4  current SR {Z,C,N,V}
- exe_s_q  out  1  EXE stage holds a valid flag-setting instruction

Behaviour:
- Reset (rst=0, asynchronous): sr_q=4'b0000, exe_valid=0, exe_s_q=0.
  - Outputs then read: id_exec = id_valid & cond_pass(0000), flag_stall=0, alu_carry_in=0.
- Condition pass is combinational on sr_q (Z=sr_q[3], C=sr_q[2], N=sr_q[1], V=sr_q[0]):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 never (0)
- id_exec = id_valid & cond_pass & ~flag_stall & ~flush. Combinational, zero latency.
- Flag hazard: flag_stall = id_valid & exe_s_q & (id_cond != 4'b1110) & ~flush.
  - Lasts exactly 1 cycle per hazard, because the bubble clears exe_s_q.
  - An AL instruction never stalls.
- EXE tracking register, updated at posedge clk, first matching rule wins:
  1. freeze=1: exe_valid and exe_s_q hold.
  2. flush=1 or flag_stall=1: exe_valid←0, exe_s_q←0 (bubble).
  3. Otherwise: exe_valid←id_exec, exe_s_q←id_exec & id_s.
- SR update at posedge clk: if exe_s_q=1 and freeze=0, then sr_q←exe_status. Otherwise sr_q holds.
  - flush does not block this write; the branching EXE instruction itself commits.
- Data inspected by the condition logic is never taken from exe_status; forwarding is replaced by the stall.
- alu_carry_in = sr_q[2] combinationally. ADC/SBC in EXE use SR as of the start of that cycle.
- Simultaneous events:
  - freeze & flush: freeze dominates; the flush source must hold flush until freeze drops.
  - freeze & flag_stall: hold, and flag_stall stays asserted.
  - Reset mid-stall: all state clears, and the stall drops in the same cycle reset asserts.
- No X propagation: an unknown id_cond with id_valid=0 must give id_exec=0 and flag_stall=0.

Test Plan:
- Release reset; id_valid=1, id_cond=1110 -> id_exec=1, sr_q=0000, alu_carry_in=0.
- EXE holds an S instruction, exe_status=1000 (Z); ID has cond 0000 EQ, id_valid=1 -> flag_stall=1 and id_exec=0 for exactly 1 cycle. Next cycle: sr_q=1000, flag_stall=0, id_exec=1.
- sr_q=0100 (C=1, Z=0): cond 1000 HI -> pass; cond 1001 LS -> fail; alu_carry_in=1. With sr_q=0011 (N=V=1): GE pass, LT fail, GT pass.
- freeze=1 for 3 cycles with exe_s_q=1 and exe_status=0001 -> sr_q unchanged and exe_s_q stays 1. First cycle after release -> sr_q=0001.
- flush=1 with an ID S instruction, cond AL -> id_exec=0; next cycle exe_s_q=0 and flag_stall=0. SR still takes the EXE instruction's status if exe_s_q was 1.
- Pull rst low asynchronously mid-cycle while flag_stall=1 and sr_q=1111 -> sr_q=0000, exe_s_q=0 and flag_stall=0 immediately, without waiting for a clock edge.
